// File: rtl/dec_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin decoder arbiter.
package dec_rr_arbiter_pkg;

    localparam int SEL_W  = 5;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Advance an index by one, wrapping at n rather than at 2**SEL_W.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v, input int n);
        if (int'(v) >= n - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/dec_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter that feeds the decoder.
interface dec_rr_arbiter_if #(parameter int N = 32);
    import dec_rr_arbiter_pkg::*;

    logic [N-1:0]     req;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic             busy;

    modport master (input req, output sel, output en, output busy);
    modport slave  (output req, input sel, input en, input busy);
endinterface

// File: rtl/dec_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 32
) (
    input  logic [N-1:0] req,
    input  logic [4:0]   ptr,
    output logic [4:0]   winner,
    output logic         any
);
    logic [63:0] req_ext;
    logic [5:0]  idx;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        winner         = '0;
        any            = 1'b0;
        idx            = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + 6'(i);
            if (idx >= 6'(N)) begin
                idx = idx - 6'(N);
            end
            if (!any && req_ext[idx]) begin
                any    = 1'b1;
                winner = idx[4:0];
            end
        end
    end
endmodule

// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter driving the select/enable of the shared 5-to-32 decoder.
module dec_rr_arbiter
    import dec_rr_arbiter_pkg::*;
#(
    parameter int N        = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    dec_rr_arbiter_if.master  bus
);
    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [SEL_W-1:0]  winner;
    logic              any_req;
    logic              own_req;
    logic              other_req;

    rr_pick #(.N(N)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any_req)
    );

    // Split the request vector into the current holder and everyone else.
    always_comb begin
        own_req   = 1'b0;
        other_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (5'(i) == sel_q) begin
                own_req = own_req | bus.req[i];
            end else begin
                other_req = other_req | bus.req[i];
            end
        end
    end

    // State and datapath registers; reset wins over any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state logic: grant, hold quota, preemption and the one-cycle gap.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = GRANT;
                    sel_d      = winner;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    state_d = GAP;
                    ptr_d   = wrap_inc(sel_q, N);
                end else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
                    if (other_req) begin
                        state_d = GAP;
                        ptr_d   = wrap_inc(sel_q, N);
                    end else begin
                        hold_cnt_d = '0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (any_req) begin
                    state_d    = GRANT;
                    sel_d      = winner;
                    hold_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from flops, so req never reaches them combinationally.
    always_comb begin
        bus.sel  = sel_q;
        bus.en   = (state_q == GRANT);
        bus.busy = (state_q != IDLE);
    end
endmodule

// File: doc/dec_rr_arbiter.md
# dec_rr_arbiter

Round-robin arbiter that shares the team's 5-to-32 decoder among up to 32 requesters. It drives the decoder's 5-bit select and enable so that exactly one decoder output line is active for the granted requester. Each grant is bounded by a hold quota, and a one-cycle break-before-make gap separates grants. It sits directly in front of the `fivetothirtytwo` decoder; `sel` connects to `in` and `en` connects to `en`.

## Interface
- `N`, default 32: number of requesters, 2..32. `req` bits at index N and above do not exist.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while others wait, 1..255.
- `clk` input, 1 bit: single clock, all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `req` input, N bits: request per requester, level-sensitive, sampled every rising edge.
- `sel` output, 5 bits: granted index, drives the decoder `in`. Registered.
- `en` output, 1 bit: grant valid, drives the decoder `en`. Registered.
- `busy` output, 1 bit: high in GRANT or GAP. Registered.

## Operation
- **State machine:** three states, IDLE, GRANT and GAP. Internal registers:
  - `ptr`, 5 bits: highest-priority index.
  - `hold_cnt`, 8 bits.
- **Arbitration function (combinational):**
  - Result is the first set bit of `req` scanning `ptr`, `ptr+1`, …, N-1, then 0, …, `ptr-1`.
  - Wrap is modulo N, not modulo 32.
- **IDLE:**
  - `en=0`, `busy=0`.
  - If any `req` bit is set, move to GRANT: `sel` ← winner, `en` ← 1, `hold_cnt` ← 0.
- **GRANT:** `en=1`, `busy=1`. At each edge:
  - If `req[sel]=0`, move to GAP.
  - Otherwise, if `hold_cnt = MAX_HOLD-1`:
    - If any other `req` bit is set, move to GAP (preemption).
    - If none is set, set `hold_cnt` ← 0 and stay; the grant continues with no gap.
  - Otherwise, `hold_cnt` increments.
  - Whenever GRANT is exited, `ptr` ← (`sel`+1) mod N.
- **GAP:** exactly one cycle, `en=0`, `busy=1`, `sel` holds its last value. At the edge:
  - Arbitrate on `req` as sampled in the GAP cycle, using the updated `ptr`.
  - If there is a winner, go to GRANT (`sel` ← winner, `hold_cnt` ← 0); otherwise go to IDLE.
- **Simultaneous events:** requester drop and quota expiry in the same cycle go to GAP, same as a drop. A requester that rises during GAP is eligible at the end of that GAP.
- **Reset (from any state, including mid-grant):**
  - At the next edge: state IDLE, `sel=0`, `en=0`, `busy=0`, `ptr=0`, `hold_cnt=0`.
  - `req` is ignored while `rst=1`.
- **Invariant:** `en=1` implies `req[sel]` was 1 at the previous edge. `en` never stays high across a change of `sel`.

## Timing
- **Request latency:** `req` rising in IDLE gives `en=1` with a valid `sel` one cycle later.
- **Release latency:** `req[sel]` falling gives `en=0` one cycle later.
- **Back-to-back handover:** last grant cycle, then one GAP cycle with `en=0`, then the next grant. The minimum idle between grants is 1 cycle.
- **Contention:** with contention, a grant lasts at most `MAX_HOLD` cycles. The worst-case wait for any requester is (N-1)·(`MAX_HOLD`+1) cycles.
- **Outputs:** all are registered; there is no combinational path from `req` to `sel`, `en` or `busy`.

## Structure
- **Shared package:** state enum (IDLE, GRANT, GAP), `SEL_W=5`, `HOLD_W=8`.
- **Sub-module `rr_pick`:** combinational, takes `req`, `ptr` and `N` and returns `winner[4:0]` and `any`. It is reusable by other arbiters.
- **Top level:** FSM plus the `ptr` and `hold_cnt` registers. The decoder is not instantiated inside this block; it is wired at the parent level.

## Test plan
All cases use `N=32`, `MAX_HOLD=4` unless stated.
- **Reset with requests pending:** `rst=1` for 2 cycles with `req=0xFFFFFFFF`.
  - During reset: `en=0`, `sel=0`, `busy=0`.
  - First edge after release: `sel=0`, `en=1`.
- **Single requester:** `req=0x00000004` held 3 cycles, then 0.
  - `en=1`, `sel=2` for 3 cycles, starting 1 cycle after `req` rises.
  - Then one GAP cycle (`busy=1`, `en=0`), then IDLE (`busy=0`).
- **Preemption round-robin:** `req=0x00000009` held constant.
  - Sequence repeats: `sel=0` for 4 cycles, GAP, `sel=3` for 4 cycles, GAP, `sel=0` …
- **Wrap-around:** after a grant to 31 ends, `req=0x80000002`.
  - Next grant is `sel=1` (`ptr` wrapped to 0).
  - Repeat with `N=20`: after a grant to 19, `req` bits 19 and 2 set, next grant is 2.
- **Sole requester past quota:** `req=0x80000000` held 20 cycles.
  - `en` stays 1 and `sel=31` continuously with no GAP.
  - `en` falls 1 cycle after `req` drops.
- **Reset mid-grant:** `rst` pulsed on the 2nd cycle of a grant to 5.
  - Next edge: `en=0`, `sel=0`.
  - With `req` bits 5 and 1 set after release, 1 wins (`ptr=0`).
